// File: rtl/stream_demux_n_if.sv
// Handshake bundle between one producer, N consumer channels and the demux stage.
// The master side drives the producer inputs and the per-channel readies.
interface stream_demux_n_if #(
    parameter int N_CH   = 8,
    parameter int SEL_W  = 3,
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [SEL_W-1:0]  in_sel;
    logic              in_bcast;
    logic [N_CH-1:0]   out_valid;
    logic [N_CH-1:0]   out_ready;
    logic [DATA_W-1:0] out_data;
    logic [N_CH-1:0]   dec;
    logic              err;
    logic [7:0]        err_cnt;

    modport master (
        output in_valid, in_data, in_sel, in_bcast, out_ready,
        input  in_ready, out_valid, out_data, dec, err, err_cnt
    );

    modport slave (
        input  in_valid, in_data, in_sel, in_bcast, out_ready,
        output in_ready, out_valid, out_data, dec, err, err_cnt
    );
endinterface

// File: rtl/stream_demux_n.sv
// Registered 1-to-N stream demux: one holding register, unicast or broadcast delivery,
// per-channel drain, decoded pending mask and a saturating drop counter.
module stream_demux_n #(
    parameter int N_CH       = 8,
    parameter int SEL_W      = 3,
    parameter int DATA_W     = 8,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    stream_demux_n_if.slave   bus
);
    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t            state;
    logic [N_CH-1:0]   pending_reg;
    logic [N_CH-1:0]   pending_next;
    logic [N_CH-1:0]   still_pending;
    logic [N_CH-1:0]   sel_onehot;
    logic [DATA_W-1:0] data_reg;
    logic [DATA_W-1:0] data_next;
    logic              err_reg;
    logic              err_next;
    logic [7:0]        err_cnt_reg;
    logic [7:0]        err_cnt_next;
    logic              in_range;
    logic              accept;

    // An out-of-range select decodes to no channel at all, so the OR of the
    // one-hot doubles as the range check.
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        assign sel_onehot[gi] = (bus.in_sel == SEL_W'(gi));
        assign bus.dec[gi]    = pending_reg[gi] ^ ACTIVE_LOW;
    end

    assign in_range      = |sel_onehot;
    assign state         = (pending_reg == '0) ? EMPTY : HOLD;
    assign still_pending = pending_reg & ~bus.out_ready;

    assign bus.in_ready  = (still_pending == '0);
    assign bus.out_valid = pending_reg;
    assign bus.out_data  = data_reg;
    assign bus.err       = err_reg;
    assign bus.err_cnt   = err_cnt_reg;

    always_comb begin
        pending_next = still_pending;
        data_next    = data_reg;
        err_next     = 1'b0;
        err_cnt_next = err_cnt_reg;
        accept       = 1'b0;

        case (state)
            EMPTY:   accept = bus.in_valid;
            HOLD:    accept = bus.in_valid & bus.in_ready;
            default: accept = 1'b0;
        endcase

        // A new item replaces whatever mask just finished draining.
        if (accept) begin
            if (bus.in_bcast) begin
                pending_next = '1;
                data_next    = bus.in_data;
            end else if (in_range) begin
                pending_next = sel_onehot;
                data_next    = bus.in_data;
            end else begin
                err_next = 1'b1;
                if (err_cnt_reg != 8'hFF) begin
                    err_cnt_next = err_cnt_reg + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_reg <= '0;
            data_reg    <= '0;
            err_reg     <= 1'b0;
            err_cnt_reg <= 8'd0;
        end else begin
            pending_reg <= pending_next;
            data_reg    <= data_next;
            err_reg     <= err_next;
            err_cnt_reg <= err_cnt_next;
        end
    end
endmodule

// File: doc/stream_demux_n.md
# stream_demux_n

Parametrised, registered 1-to-N stream demultiplexer with valid/ready handshake, unicast and broadcast modes, and a decoded channel-select output of selectable polarity. It generalises the team's fixed 1-to-8 active-low decoder/demux into a clocked routing stage. It sits between a single producer and N consumer channels, for example a command bus fanning out to peripheral slots. Defaults reproduce the 8-channel, active-low decode behaviour.

## Interface
- N_CH, 8: number of output channels, 2..64.
- SEL_W, 3: select width; must satisfy 2^SEL_W >= N_CH.
- DATA_W, 8: payload width, >= 1.
- ACTIVE_LOW, 1: 1 makes `dec` active-low (idle = all ones); 0 makes it active-high.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  producer has an item.
- in_ready  out  1  stage can accept; an item transfers on in_valid & in_ready.
- in_data  in  DATA_W  payload.
- in_sel  in  SEL_W  target channel index (unicast).
- in_bcast  in  1  1 sends the item to all N_CH channels; in_sel is ignored.
- out_valid  out  N_CH  per-channel valid.
- out_ready  in  N_CH  per-channel ready.
- out_data  out  DATA_W  held payload, shared by all channels.
- dec  out  N_CH  decoded pending-channel mask, polarity per ACTIVE_LOW.
- err  out  1  one-cycle pulse when an out-of-range item is dropped.
- err_cnt  out  8  saturating count of dropped items.

## Operation
- Single holding register: `data` (DATA_W bits) and `pending` (an N_CH-bit mask).
- States, derived from `pending`:
  - EMPTY: pending == 0.
  - HOLD: pending != 0.
- Accept conditions:
  - Unicast with in_sel < N_CH: pending <= one-hot(in_sel).
  - Broadcast: pending <= all ones.
  - data <= in_data on every accept.
- Out-of-range unicast (in_sel >= N_CH):
  - The item is accepted (handshake completes) but not stored.
  - err pulses high for one cycle; err_cnt increments and saturates at 255.
  - pending is unaffected by this item.
- Output mapping:
  - out_valid = pending.
  - out_data = data.
  - dec = pending when ACTIVE_LOW = 0, ~pending when ACTIVE_LOW = 1.
- Per-cycle drain: pending_next = pending & ~out_ready.
  - Each broadcast channel drops its valid after its own handshake.
  - Channels accept independently and in any order.
- in_ready = (pending & ~out_ready) == 0. This is a combinational path from out_ready; it allows a back-to-back accept in the same cycle the last pending channel drains.
- When an accept and a drain complete in the same cycle, the new item's mask replaces the drained one. Data is never overwritten while any channel is still pending.
- out_data and pending must be stable while pending != 0 and the relevant out_ready is low.
- Reset (asynchronous, immediate):
  - pending = 0, data = 0, err = 0, err_cnt = 0.
  - dec = all ones (ACTIVE_LOW = 1) or all zeros (ACTIVE_LOW = 0).
  - in_ready = 1 while rst is low and the stage is empty.
- Reset mid-operation discards any held item; there is no partial delivery after release.

## Timing
- Latency: an item accepted at edge k shows out_valid at edge k (registered output visible in cycle k+1).
- Throughput: one item per cycle when the targeted channel(s) hold out_ready high.
- Broadcast occupancy:
  - Minimum 1 cycle with all out_ready high.
  - Otherwise it lasts until the last channel handshakes.
- err is registered and asserts the cycle after the dropping handshake.
- No combinational path from in_* to out_*.
- The only combinational input-to-output path is out_ready to in_ready.

## Test plan
- Reset with ACTIVE_LOW=1, N_CH=8: out_valid=0x00, dec=0xFF, err_cnt=0, in_ready=1. Assert rst mid-HOLD: all outputs return to these values asynchronously.
- Unicast, in_sel=5, in_data=0xA5, out_ready=0xFF:
  - Next cycle: out_valid=0x20, dec=0xDF, out_data=0xA5.
  - Streaming sel 0..7 on consecutive cycles yields one item per cycle, in order.
- Backpressure, unicast sel=2 with out_ready[2]=0 for 4 cycles:
  - in_ready=0 and out_data is held throughout.
  - out_ready[2]=1 produces a same-cycle accept of the next item.
- Broadcast with data 0x3C, out_ready rising one bit per cycle from 0x01 to 0xFF:
  - pending drains 0xFF → 0xFE → 0xFC … → 0x00.
  - in_ready rises only in the cycle in which bit 7 handshakes.
- Out-of-range drop, N_CH=6, SEL_W=3, in_sel=6 then 7:
  - Two err pulses, err_cnt=2, out_valid stays 0.
  - Drive 300 bad items: err_cnt saturates at 255.
- ACTIVE_LOW=0, N_CH=5: unicast sel=4 gives dec=0x10; idle gives dec=0x00.
